// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy scoreboard; register 0 hardwired to zero.
// Reads are combinational (0 cycles); writes and scoreboard updates land at the next rising edge.
// No backpressure: every request is accepted each cycle; optional REGFILE_BYPASS_EN adds write-through forwarding.
module regfile_scoreboard #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [ADDR_W-1:0]      rd0_addr,
  output logic [DATA_W-1:0]      rd0_data,
  output logic                   rd0_busy,
  input  logic [ADDR_W-1:0]      rd1_addr,
  output logic [DATA_W-1:0]      rd1_data,
  output logic                   rd1_busy,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  input  logic                   flush,
  output logic [2**ADDR_W-1:0]   busy_vec
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_nxt;
  logic              wr_live;

  // Register 0 never accepts a write, so the write path ignores it entirely.
  assign wr_live = wr_en && (wr_addr != '0);

  // Scoreboard next state: flush, then reserve (younger owner), then release, else hold.
  always_comb begin
    busy_nxt = busy;
    busy_nxt[0] = 1'b0;
    for (int i = 1; i < NREGS; i++) begin
      if (flush) begin
        busy_nxt[i] = 1'b0;
      end else if (rsv_en && (rsv_addr == ADDR_W'(i))) begin
        busy_nxt[i] = 1'b1;
      end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
        busy_nxt[i] = 1'b0;
      end
    end
  end

  // Data array and scoreboard state; reset wins over any pending write or reservation.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (wr_live) begin
        regs[wr_addr] <= wr_data;
      end
      busy <= busy_nxt;
    end
  end

  assign busy_vec = busy;

`ifdef REGFILE_BYPASS_EN
  logic byp0;
  logic byp1;
  logic rsv0;
  logic rsv1;

  // Forward an in-flight write to a matching read port; busy forwarding mirrors the edge priority.
  always_comb begin
    byp0 = reset && wr_live && (wr_addr == rd0_addr);
    byp1 = reset && wr_live && (wr_addr == rd1_addr);
    rsv0 = rsv_en && (rsv_addr == rd0_addr);
    rsv1 = rsv_en && (rsv_addr == rd1_addr);

    rd0_data = (rd0_addr == '0) ? '0 : regs[rd0_addr];
    rd0_busy = busy[rd0_addr];
    rd1_data = (rd1_addr == '0) ? '0 : regs[rd1_addr];
    rd1_busy = busy[rd1_addr];

    if (byp0) begin
      rd0_data = wr_data;
      if (!flush) rd0_busy = rsv0;
    end
    if (byp1) begin
      rd1_data = wr_data;
      if (!flush) rd1_busy = rsv1;
    end
  end
`else
  // Reads reflect only state registered at the previous edge.
  always_comb begin
    rd0_data = (rd0_addr == '0) ? '0 : regs[rd0_addr];
    rd0_busy = busy[rd0_addr];
    rd1_data = (rd1_addr == '0) ? '0 : regs[rd1_addr];
    rd1_busy = busy[rd1_addr];
  end
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with an expected-value queue.
// Each step drives stimulus, pushes expected values, then pops and compares sampled outputs.
// Outputs are sampled 1-2 time units after the rising edge, away from the active edge.
module tb_regfile_scoreboard;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 2**ADDR_W;

  logic              clock;
  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd0_addr;
  logic [DATA_W-1:0] rd0_data;
  logic              rd0_busy;
  logic [ADDR_W-1:0] rd1_addr;
  logic [DATA_W-1:0] rd1_data;
  logic              rd1_busy;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              flush;
  logic [NREGS-1:0]  busy_vec;

  regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd0_addr (rd0_addr),
    .rd0_data (rd0_data),
    .rd0_busy (rd0_busy),
    .rd1_addr (rd1_addr),
    .rd1_data (rd1_data),
    .rd1_busy (rd1_busy),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .flush    (flush),
    .busy_vec (busy_vec)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL queue_underflow observed=%h expected=<entry>", obs);
    end else begin
      e = exp_q.pop_front();
      vectors++;
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    rsv_en = 1'b0;
    flush  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset held for two edges with a write pending; the write must be ignored.
    reset = 1'b0; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hABCD;
    rsv_en = 1'b0; rsv_addr = 3'd0; flush = 1'b0; rd0_addr = 3'd0; rd1_addr = 3'd0;
    tick();
    tick();
    reset = 1'b1; idle(); rd0_addr = 3'd3; rd1_addr = 3'd3;
    push("rst_rd0_data", 32'h0);
    push("rst_rd1_data", 32'h0);
    push("rst_rd0_busy", 32'h0);
    push("rst_busy_vec", 32'h0);
    #1;
    pop_chk(32'(rd0_data)); pop_chk(32'(rd1_data));
    pop_chk(32'(rd0_busy)); pop_chk(32'(busy_vec));

    // Plain write, then both ports read the same register.
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234;
    tick();
    idle(); rd0_addr = 3'd5; rd1_addr = 3'd5;
    push("wr5_rd0_data", 32'h1234);
    push("wr5_rd1_data", 32'h1234);
    push("wr5_rd0_busy", 32'h0);
    push("wr5_rd1_busy", 32'h0);
    #1;
    pop_chk(32'(rd0_data)); pop_chk(32'(rd1_data));
    pop_chk(32'(rd0_busy)); pop_chk(32'(rd1_busy));

    // Write to register 0 is discarded.
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
    tick();
    idle(); rd0_addr = 3'd0; rd1_addr = 3'd5;
    push("r0_rd0_data", 32'h0);
    push("r0_keep_r5", 32'h1234);
    #1;
    pop_chk(32'(rd0_data)); pop_chk(32'(rd1_data));

    // Reserve reg 4, then release it with a write.
    rsv_en = 1'b1; rsv_addr = 3'd4;
    tick();
    idle(); rd1_addr = 3'd4;
    push("rsv4_rd1_busy", 32'h1);
    push("rsv4_busy_vec", 32'h10);
    #1;
    pop_chk(32'(rd1_busy)); pop_chk(32'(busy_vec));
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h0042;
    tick();
    idle();
    push("rel4_busy_vec", 32'h0);
    push("rel4_rd1_data", 32'h0042);
    #1;
    pop_chk(32'(busy_vec)); pop_chk(32'(rd1_data));

    // Reserve and write the same register in one cycle: data lands, reserve wins.
    rsv_en = 1'b1; rsv_addr = 3'd6; wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h0777;
    tick();
    idle(); rd0_addr = 3'd6;
    push("rw6_rd0_data", 32'h0777);
    push("rw6_busy_vec", 32'h40);
    #1;
    pop_chk(32'(rd0_data)); pop_chk(32'(busy_vec));

    // Reservation of register 0 is discarded.
    rsv_en = 1'b1; rsv_addr = 3'd0;
    tick();
    idle(); rd1_addr = 3'd0;
    push("rsv0_busy_vec", 32'h40);
    push("rsv0_rd1_busy", 32'h0);
    #1;
    pop_chk(32'(busy_vec)); pop_chk(32'(rd1_busy));

    // Release reg 6, reserve 1, 2, 7.
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h0777;
    tick();
    idle(); rsv_en = 1'b1; rsv_addr = 3'd1;
    tick();
    rsv_addr = 3'd2;
    tick();
    rsv_addr = 3'd7;
    tick();
    idle();
    push("rsv127_busy_vec", 32'h86);
    #1;
    pop_chk(32'(busy_vec));

    // Flush beats a concurrent reservation; the concurrent write still lands.
    flush = 1'b1; rsv_en = 1'b1; rsv_addr = 3'd3;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0055;
    tick();
    idle(); rd0_addr = 3'd2; rd1_addr = 3'd3;
    push("flush_busy_vec", 32'h0);
    push("flush_wr2_data", 32'h0055);
    push("flush_rd1_busy", 32'h0);
    #1;
    pop_chk(32'(busy_vec)); pop_chk(32'(rd0_data)); pop_chk(32'(rd1_busy));

    // Same-cycle read of a busy register being written.
    rsv_en = 1'b1; rsv_addr = 3'd2;
    tick();
    idle();
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hBEEF; rd0_addr = 3'd2;
`ifdef REGFILE_BYPASS_EN
    push("same_cyc_rd0_data", 32'hBEEF);
    push("same_cyc_rd0_busy", 32'h0);
`else
    push("same_cyc_rd0_data", 32'h0055);
    push("same_cyc_rd0_busy", 32'h1);
`endif
    #1;
    pop_chk(32'(rd0_data)); pop_chk(32'(rd0_busy));
    tick();
    idle();
    push("after_wr2_rd0_data", 32'hBEEF);
    push("after_wr2_rd0_busy", 32'h0);
    #1;
    pop_chk(32'(rd0_data)); pop_chk(32'(rd0_busy));

    // Reset mid-operation overrides a pending reservation and write.
    rsv_en = 1'b1; rsv_addr = 3'd5; wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h9999;
    reset = 1'b0;
    tick();
    reset = 1'b1; idle(); rd0_addr = 3'd5; rd1_addr = 3'd2;
    push("midrst_busy_vec", 32'h0);
    push("midrst_rd0_data", 32'h0);
    push("midrst_rd1_data", 32'h0);
    #1;
    pop_chk(32'(busy_vec)); pop_chk(32'(rd0_data)); pop_chk(32'(rd1_data));

    if (exp_q.size() != 0) begin
      miscompares++;
      $error("FAIL queue_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
